// File: rtl/calc_sequencer.sv
// Calculator control sequencer: collects keypad events, captures operands, drives the ALU handshake.
// Optional CALC_CHAIN_EN: operator/equals in RESULT chain onto the previous result.
module calc_sequencer #(
  parameter int MAX_DIGITS  = 10,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [31:0] operand_in,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        alu_err,
  output logic        input_clr_n,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [1:0]  opcode,
  output logic        alu_start,
  output logic [1:0]  disp_sel,
  output logic [3:0]  digit_cnt,
  output logic        busy,
  output logic        error
);

  localparam int TW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(ALU_TIMEOUT - 1);
  localparam logic [3:0]    DIGIT_LIMIT = 4'(MAX_DIGITS);

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_OP_WAIT,
    S_ENTER_B,
    S_EXEC,
    S_RESULT,
    S_ERR
  } state_t;

  state_t         r_state;
  logic [31:0]    r_op_a;
  logic [31:0]    r_op_b;
  logic [1:0]     r_opcode;
  logic [3:0]     r_digit_cnt;
  logic           r_clr_n;
  logic           r_alu_start;
  logic [TW-1:0]  r_timer;

  state_t         w_state_next;
  logic [31:0]    w_op_a_next;
  logic [31:0]    w_op_b_next;
  logic [1:0]     w_opcode_next;
  logic [3:0]     w_digit_cnt_next;
  logic           w_clr_n_next;
  logic           w_alu_start_next;
  logic [TW-1:0]  w_timer_next;

  logic           w_is_digit;
  logic           w_is_oper;
  logic           w_is_equals;
  logic           w_is_clear;
  logic [1:0]     w_key_opcode;
  logic           w_can_add_digit;

  assign w_is_digit      = key_valid && (key_code <= 4'd9);
  assign w_is_oper       = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
  assign w_is_equals     = key_valid && (key_code == 4'hE);
  assign w_is_clear      = key_valid && (key_code == 4'hF);
  // A..D map to 00..11: low two bits plus 2 wraps 10,11,00,01 onto 00,01,10,11
  assign w_key_opcode    = key_code[1:0] + 2'd2;
  assign w_can_add_digit = (r_digit_cnt < DIGIT_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_ENTER_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_opcode    <= '0;
      r_digit_cnt <= '0;
      r_clr_n     <= 1'b0;
      r_alu_start <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_op_a      <= w_op_a_next;
      r_op_b      <= w_op_b_next;
      r_opcode    <= w_opcode_next;
      r_digit_cnt <= w_digit_cnt_next;
      r_clr_n     <= w_clr_n_next;
      r_alu_start <= w_alu_start_next;
      r_timer     <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_op_a_next      = r_op_a;
    w_op_b_next      = r_op_b;
    w_opcode_next    = r_opcode;
    w_digit_cnt_next = r_digit_cnt;
    w_clr_n_next     = 1'b1;
    w_alu_start_next = 1'b0;
    w_timer_next     = r_timer;

    // Clear wins over every other key, but an operation in flight cannot be aborted
    if (w_is_clear && (r_state != S_EXEC)) begin
      w_state_next     = S_ENTER_A;
      w_op_a_next      = '0;
      w_op_b_next      = '0;
      w_opcode_next    = 2'b00;
      w_digit_cnt_next = '0;
      w_clr_n_next     = 1'b0;
    end else begin
      unique case (r_state)
        S_ENTER_A: begin
          if (w_is_digit) begin
            if (w_can_add_digit) w_digit_cnt_next = r_digit_cnt + 4'd1;
          end else if (w_is_oper && (r_digit_cnt != 4'd0)) begin
            w_op_a_next      = operand_in;
            w_opcode_next    = w_key_opcode;
            w_clr_n_next     = 1'b0;
            w_digit_cnt_next = '0;
            w_state_next     = S_OP_WAIT;
          end
        end
        S_OP_WAIT: begin
          if (w_is_oper) begin
            w_opcode_next = w_key_opcode;
          end else if (w_is_digit) begin
            w_digit_cnt_next = 4'd1;
            w_state_next     = S_ENTER_B;
          end
        end
        S_ENTER_B: begin
          if (w_is_digit) begin
            if (w_can_add_digit) w_digit_cnt_next = r_digit_cnt + 4'd1;
          end else if (w_is_equals && (r_digit_cnt != 4'd0)) begin
            w_op_b_next      = operand_in;
            w_alu_start_next = 1'b1;
            w_digit_cnt_next = '0;
            w_timer_next     = '0;
            w_state_next     = S_EXEC;
          end
        end
        S_EXEC: begin
          // Timer counts EXEC cycles from the one carrying alu_start
          if (alu_done) begin
            if (alu_err) begin
              w_state_next = S_ERR;
            end else begin
              w_op_a_next  = alu_result;
              w_state_next = S_RESULT;
            end
          end else if (r_timer == TIMER_LAST) begin
            w_state_next = S_ERR;
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
        S_RESULT: begin
          if (w_is_digit) begin
            w_clr_n_next     = 1'b0;
            w_digit_cnt_next = 4'd1;
            w_state_next     = S_ENTER_A;
          end
`ifdef CALC_CHAIN_EN
          else if (w_is_oper) begin
            w_opcode_next = w_key_opcode;
            w_state_next  = S_OP_WAIT;
          end else if (w_is_equals) begin
            w_alu_start_next = 1'b1;
            w_timer_next     = '0;
            w_state_next     = S_EXEC;
          end
`endif
        end
        S_ERR: begin
          w_state_next = S_ERR;
        end
        default: begin
          w_state_next = S_ENTER_A;
        end
      endcase
    end
  end

  always_comb begin
    disp_sel = 2'b00;
    if (r_state == S_RESULT) disp_sel = 2'b01;
    else if (r_state == S_ERR) disp_sel = 2'b10;
  end

  assign busy        = (r_state == S_EXEC);
  assign error       = (r_state == S_ERR);
  assign input_clr_n = r_clr_n;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign opcode      = r_opcode;
  assign alu_start   = r_alu_start;
  assign digit_cnt   = r_digit_cnt;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random keys against a key-event model.
// Honors CALC_CHAIN_EN the same way as the design.
module tb_calc_sequencer;

  localparam int MAXD = 10;
  localparam int TMO  = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] operand_in;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        alu_err;
  logic        input_clr_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  opcode;
  logic        alu_start;
  logic [1:0]  disp_sel;
  logic [3:0]  digit_cnt;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  calc_sequencer #(.MAX_DIGITS(MAXD), .ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .operand_in(operand_in), .alu_done(alu_done), .alu_result(alu_result),
    .alu_err(alu_err), .input_clr_n(input_clr_n), .op_a(op_a), .op_b(op_b),
    .opcode(opcode), .alu_start(alu_start), .disp_sel(disp_sel),
    .digit_cnt(digit_cnt), .busy(busy), .error(error)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  // Model: mode letters A=enter A, W=operator wait, B=enter B, X=executing, R=result, E=error
  string       m_st;
  logic [31:0] m_a, m_b;
  int          m_opc, m_cnt, m_exec;
  bit          m_clr, m_start;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input int opc, output bit err);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    err = 0;
    case (opc)
      0: r = sa + sb;
      1: r = sa - sb;
      2: r = sa * sb;
      default: if (sb == 0) err = 1; else r = sa / sb;
    endcase
    if (r > 64'sd2147483647 || r < -64'sd2147483648) err = 1;
    return r[31:0];
  endfunction

  function automatic void model_step(input bit rst_n, input bit kv, input int kc,
                                     input logic [31:0] opin, input bit dn,
                                     input logic [31:0] res, input bit er);
    bit dig, opr, eq, clk_clear;
    if (!rst_n) begin
      m_st = "A"; m_a = 0; m_b = 0; m_opc = 0; m_cnt = 0;
      m_clr = 0; m_start = 0; m_exec = 0;
      return;
    end
    m_clr = 1;
    m_start = 0;
    dig = kv && (kc <= 9);
    opr = kv && (kc >= 10) && (kc <= 13);
    eq  = kv && (kc == 14);
    clk_clear = kv && (kc == 15);
    if (clk_clear && m_st != "X") begin
      m_st = "A"; m_a = 0; m_b = 0; m_opc = 0; m_cnt = 0; m_clr = 0;
    end else if (m_st == "A") begin
      if (dig) begin
        if (m_cnt < MAXD) m_cnt++;
      end else if (opr && m_cnt > 0) begin
        m_a = opin; m_opc = kc - 10; m_clr = 0; m_cnt = 0; m_st = "W";
      end
    end else if (m_st == "W") begin
      if (opr) m_opc = kc - 10;
      else if (dig) begin m_cnt = 1; m_st = "B"; end
    end else if (m_st == "B") begin
      if (dig) begin
        if (m_cnt < MAXD) m_cnt++;
      end else if (eq && m_cnt > 0) begin
        m_b = opin; m_start = 1; m_cnt = 0; m_exec = 0; m_st = "X";
      end
    end else if (m_st == "X") begin
      m_exec++;
      if (dn) begin
        if (er) m_st = "E";
        else begin m_a = res; m_st = "R"; end
      end else if (m_exec >= TMO) m_st = "E";
    end else if (m_st == "R") begin
      if (dig) begin m_clr = 0; m_cnt = 1; m_st = "A"; end
`ifdef CALC_CHAIN_EN
      else if (opr) begin m_opc = kc - 10; m_st = "W"; end
      else if (eq) begin m_start = 1; m_exec = 0; m_st = "X"; end
`endif
    end
  endfunction

  task automatic compare_outputs();
    check_eq("input_clr_n", input_clr_n, m_clr);
    check_eq("op_a", op_a, m_a);
    check_eq("op_b", op_b, m_b);
    check_eq("opcode", opcode, m_opc);
    check_eq("alu_start", alu_start, m_start);
    check_eq("disp_sel", disp_sel, (m_st == "R") ? 1 : (m_st == "E") ? 2 : 0);
    check_eq("digit_cnt", digit_cnt, m_cnt);
    check_eq("busy", busy, m_st == "X");
    check_eq("error", error, m_st == "E");
  endtask

  // One clock: drive at negedge, model on posedge, compare at next negedge
  task automatic drive_cycle(input bit rst_n, input bit kv, input logic [3:0] kc,
                             input logic [31:0] opin, input bit dn,
                             input logic [31:0] res, input bit er);
    reset = rst_n; key_valid = kv; key_code = kc; operand_in = opin;
    alu_done = dn; alu_result = res; alu_err = er;
    @(posedge clk);
    model_step(rst_n, kv, int'(kc), opin, dn, res, er);
    @(negedge clk);
    compare_outputs();
    if (alu_start) n_starts++;
    if (kv)
      $display("[TB] key=%h opin=%h -> op_a=%h op_b=%h opcode=%0d cnt=%0d disp=%0d busy=%0b err=%0b",
               kc, opin, op_a, op_b, opcode, digit_cnt, disp_sel, busy, error);
  endtask

  task automatic key(input logic [3:0] kc, input logic [31:0] opin);
    drive_cycle(1, 1, kc, opin, 0, 32'h0, 0);
  endtask

  task automatic idle();
    drive_cycle(1, 0, 4'h0, $urandom, 0, 32'h0, 0);
  endtask

  task automatic finish_alu(input logic [31:0] res, input bit er);
    drive_cycle(1, 0, 4'h0, $urandom, 1, res, er);
  endtask

  initial begin
    reset = 0; key_valid = 0; key_code = 0; operand_in = 0;
    alu_done = 0; alu_result = 0; alu_err = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 4'h0, 32'h0, 0, 32'h0, 0);
    check_eq("rst_clr_n_low", input_clr_n, 1'b0);
    check_eq("rst_disp_sel", disp_sel, 2'b00);
    idle();
    check_eq("post_rst_clr_n", input_clr_n, 1'b1);

    // 1,2,A,7,E then result 19
    key(4'h1, 32'd1); key(4'h2, 32'd12); key(4'hA, 32'd12);
    check_eq("add_op_a", op_a, 32'd12);
    check_eq("add_clr_pulse", input_clr_n, 1'b0);
    key(4'h7, 32'd7);
    n_starts = 0;
    key(4'hE, 32'd7);
    check_eq("add_op_b", op_b, 32'd7);
    check_eq("add_opcode", opcode, 2'b00);
    idle(); idle();
    check_eq("start_pulses", n_starts, 1);
    finish_alu(32'd19, 0);
    check_eq("res_disp", disp_sel, 2'b01);
    check_eq("res_op_a", op_a, 32'd19);

`ifdef CALC_CHAIN_EN
    key(4'hB, 32'd0); key(4'h4, 32'd4); key(4'hE, 32'd4);
    check_eq("chain_op_a", op_a, 32'd19);
    check_eq("chain_opcode", opcode, 2'b01);
    check_eq("chain_op_b", op_b, 32'd4);
    finish_alu(32'd15, 0);
`else
    key(4'hB, 32'd0);
    check_eq("nochain_disp", disp_sel, 2'b01);
    check_eq("nochain_opcode", opcode, 2'b00);
    check_eq("nochain_op_a", op_a, 32'd19);
`endif

    // Digit saturation
    key(4'hF, 32'd0);
    for (int i = 0; i < 11; i++) key(4'(i % 10), $urandom);
    check_eq("digit_sat", digit_cnt, 4'd10);

    // Operator with no digits
    key(4'hF, 32'd0);
    key(4'hC, 32'd55);
    check_eq("op_nodigit_clr", input_clr_n, 1'b1);
    check_eq("op_nodigit_opa", op_a, 32'd0);

    // Divide error path, then clear
    key(4'h5, 32'd9); key(4'hD, 32'd9); key(4'h0, 32'd0); key(4'hE, 32'd0);
    finish_alu(32'd0, 1);
    check_eq("err_flag", error, 1'b1);
    check_eq("err_disp", disp_sel, 2'b10);
    key(4'h8, 32'd8);
    check_eq("err_digit_ignored", digit_cnt, 4'd0);
    key(4'hF, 32'd0);
    check_eq("clr_from_err_pulse", input_clr_n, 1'b0);
    check_eq("clr_from_err_error", error, 1'b0);
    check_eq("clr_from_err_opcode", opcode, 2'b00);

    // Timeout with clear attempts during EXEC
    key(4'h2, 32'd2); key(4'hA, 32'd2); key(4'h3, 32'd3); key(4'hE, 32'd3);
    check_eq("tmo_start", alu_start, 1'b1);
    for (int k = 1; k <= TMO - 1; k++) begin
      if (k % 50 == 0) key(4'hF, 32'd0);
      else idle();
    end
    check_eq("tmo_still_busy", busy, 1'b1);
    idle();
    check_eq("tmo_error", error, 1'b1);
    key(4'hF, 32'd0);

    // Reset during EXEC, late alu_done ignored
    key(4'h1, 32'd1); key(4'hA, 32'd1); key(4'h1, 32'd2); key(4'hE, 32'd2);
    drive_cycle(0, 0, 4'h0, 32'h0, 0, 32'h0, 0);
    idle();
    finish_alu(32'd5, 0);
    check_eq("rst_exec_busy", busy, 1'b0);
    check_eq("rst_exec_disp", disp_sel, 2'b00);

    // Random keys, ALU answers from arithmetic reference
    for (int i = 0; i < 800; i++) begin
      bit kv, dn, er;
      int r, kc;
      logic [31:0] res;
      kv = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 19);
      if (r < 10) kc = r;
      else if (r < 14) kc = r;
      else if (r < 17) kc = 14;
      else if (r == 17) kc = 15;
      else kc = $urandom_range(0, 9);
      dn = 0; er = 0; res = $urandom;
      if (m_st == "X") begin
        if ($urandom_range(0, 3) == 0) begin
          dn = 1;
          res = ref_alu(m_a, m_b, m_opc, er);
          if ($urandom_range(0, 7) == 0) er = 1;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dn = 1; er = ($urandom_range(0, 1) == 1);
      end
      drive_cycle(1, kv, 4'(kc), $urandom, dn, res, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter MAX_DIGITS, default 10: maximum decimal digits accepted per operand.
REQ-002 Parameter ALU_TIMEOUT, default 255: cycles to wait for alu_done before flagging error.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
REQ-006 key_code  input  4  0-9 digit, A add, B sub, C mul, D div, E equals, F clear.
REQ-007 operand_in  input  32  two's-complement operand from the input unit.
REQ-008 alu_done  input  1  one-cycle strobe; alu_result and alu_err are valid.
REQ-009 alu_result  input  32  arithmetic result.
REQ-010 alu_err  input  1  overflow or divide-by-zero from the arithmetic unit.
REQ-011 input_clr_n  output  1  one-cycle active-low clear to the input unit.
REQ-012 op_a, op_b  output  32 each  registered operands.
REQ-013 opcode  output  2  00 add, 01 sub, 10 mul, 11 div.
REQ-014 alu_start  output  1  one-cycle start strobe.
REQ-015 disp_sel  output  2  00 entry, 01 result, 10 error.
REQ-016 digit_cnt  output  4  digits accepted in the current operand.
REQ-017 busy  output  1  high in EXEC.
REQ-018 error  output  1  high in ERR.

Function
REQ-019 States: ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT, ERR.
REQ-020 ENTER_A: a digit with digit_cnt<MAX_DIGITS increments digit_cnt; digits at the limit are ignored.
REQ-021 ENTER_A: an operator with digit_cnt>0 captures operand_in into op_a, latches opcode, pulses input_clr_n, clears digit_cnt and goes to OP_WAIT; with digit_cnt=0 the operator is ignored.
REQ-022 OP_WAIT: a new operator replaces opcode; a digit goes to ENTER_B with digit_cnt=1; equals is ignored.
REQ-023 ENTER_B follows the REQ-020 digit rule; operators are ignored.
REQ-024 ENTER_B: equals with digit_cnt>0 captures operand_in into op_b, asserts alu_start for exactly one cycle and goes to EXEC.
REQ-025 EXEC ignores all keys, including clear.
REQ-026 EXEC exit on alu_done: alu_err=0 goes to RESULT, alu_err=1 goes to ERR.
REQ-027 EXEC timeout: if ALU_TIMEOUT cycles pass after alu_start without alu_done, go to ERR.
REQ-028 RESULT: alu_result is registered into op_a and disp_sel=01.
REQ-029 RESULT: a digit pulses input_clr_n, sets digit_cnt=1 and goes to ENTER_A.
REQ-030 ERR accepts only clear; all other keys are ignored.
REQ-031 Clear (F) in any state except EXEC pulses input_clr_n and returns to ENTER_A with op_a=op_b=0, opcode=00 and digit_cnt=0.
REQ-032 Clear takes priority over any other key action in the same cycle.
REQ-033 input_clr_n pulses occur in the cycle after the causing key_valid.
REQ-034 A capture into op_a or op_b uses operand_in sampled in the same cycle as the capturing key_valid.
REQ-035 disp_sel is 00 in ENTER_A, OP_WAIT, ENTER_B and EXEC, 01 in RESULT and 10 in ERR.
REQ-036 alu_done outside EXEC is ignored.

Reset
REQ-037 While reset=0 at a clock edge: state=ENTER_A, op_a=op_b=0, opcode=00, digit_cnt=0, alu_start=0, busy=0, error=0, disp_sel=00, input_clr_n=0.
REQ-038 After reset=1, input_clr_n is 1 until the next clear event.
REQ-039 Reset asserted during EXEC abandons the operation; a later alu_done is ignored per REQ-036.

Configuration
REQ-040 With macro CALC_CHAIN_EN defined: an operator in RESULT keeps op_a as the result, latches opcode and goes to OP_WAIT.
REQ-041 With CALC_CHAIN_EN defined: equals in RESULT re-executes with the previous op_b and opcode, pulsing alu_start and entering EXEC.
REQ-042 Without CALC_CHAIN_EN: operator and equals keys in RESULT are ignored.

Verification
REQ-043 Keys 1,2,A,7,E with operand_in 12 then 7 -> op_a=12, op_b=7, opcode=00, one alu_start pulse; alu_done with result 19 -> disp_sel=01, op_a=19.
REQ-044 Eleven digit keys in ENTER_A -> digit_cnt saturates at 10.
REQ-045 Operator key with digit_cnt=0 -> state stays ENTER_A, no input_clr_n pulse.
REQ-046 D then E, alu_done with alu_err=1 -> ERR, error=1, disp_sel=10; digit key ignored; F -> ENTER_A and all outputs at their reset values apart from input_clr_n pulse.
REQ-047 alu_start with no alu_done for 255 cycles -> ERR; F during EXEC has no effect.
REQ-048 CALC_CHAIN_EN defined: result 19, then B, 4, E -> op_a=19, opcode=01, op_b=4; undefined: B in RESULT -> no state change.
